tristate_bus_arbiter: RTL and testbench
=======================================

// Module: tristate_bus_arbiter
// PURPOSE
//  Parametrised successor to the single tri-state (inverting) buffer: N request channels share one W-bit tri-state bus.
//  A round-robin arbiter grants one channel at a time and drives its data (optionally inverted) for a burst.
//  After each burst the bus is held high-Z for a turnaround gap. Sits between local producers and a shared board/bus wire.
// PARAMETERS
//  N          4  number of channels (>=1)
//  W          8  bus/data width in bits
//  MAX_BURST  4  max accepted beats per grant; 0 = unlimited
//  TURN_CYC   1  high-Z turnaround cycles after each burst (>=1)
//  INVERT     1  1: Bus = ~Data[owner]; 0: Bus = Data[owner]
// PORTS
//  Clk      in     1          clock, all state updates on rising edge
//  Rst      in     1          synchronous, active-high reset
//  Req      in     N          per-channel request / beat-valid
//  Data     in     N*W        channel i data at [i*W +: W]
//  Last     in     N          final beat of burst for channel i
//  Gnt      out    N          one-hot grant (registered)
//  Bus      inout  W          shared tri-state bus; 'z unless driving
//  BusValid out    1          Bus carries a valid beat this cycle
//  Owner    out    clog2(N)   index of granted channel (0 when N=1)
// BEHAVIOUR
//  Reset (Rst=1 at edge): state IDLE, Gnt=0, BusValid=0, Bus='z, Owner=0, rr pointer=0, beat count=0.
//  States: IDLE -> DRIVE -> TURN -> IDLE.
//  IDLE: if |Req, winner = first requester at/after pointer, wrapping N-1 -> 0; next edge: DRIVE, Gnt=onehot(winner),
//   Owner=winner, count=0. Req seen at edge t -> Gnt high after edge t (1-cycle latency). No Req: stay IDLE.
//  DRIVE: Bus = INVERT ? ~Data[Owner] : Data[Owner] (combinational from Data, no extra latency);
//   BusValid = Req[Owner]. Beat accepted when Gnt[i] & Req[i]; count increments per accepted beat.
//  DRIVE exit (next edge -> TURN, Gnt=0, pointer=Owner+1 mod N) on any of:
//   accepted beat with Last[Owner]=1; accepted beat making count==MAX_BURST (MAX_BURST!=0); Req[Owner]=0.
//  TURN: Bus='z, Gnt=0, BusValid=0 for exactly TURN_CYC cycles, then IDLE. Gnt-low gap between bursts = TURN_CYC+1.
//  Bus is driven only in DRIVE; no path drives it in IDLE/TURN/reset.
//  Other channels' Req/Data/Last ignored while not owner; requests stay pending, no loss.
//  Simultaneous Last and MAX_BURST hit: single exit, identical result. N=1: pointer stays 0, channel regranted after TURN.
//  Rst mid-burst: at that edge all state returns to reset values; Bus 'z from that edge; partial burst abandoned.
//  count width clog2(MAX_BURST+1); saturates/never wraps within a grant.
// STRUCTURE
//  tsb_defs.vh: state encodings (ST_IDLE, ST_DRIVE, ST_TURN), width helper constants.
//  Sub-module rr_arbiter: N-bit req + pointer -> one-hot grant + index, purely combinational.
//  Top: FSM, burst/turn counters, pointer reg, tri-state drive with INVERT mux.
// TESTING (N=4, W=8, MAX_BURST=4, TURN_CYC=1, INVERT=1 unless noted)
//  Rst=1 two cycles, Req=4'b1111 -> Gnt=0, BusValid=0, Bus=8'hzz, Owner=0 throughout.
//  Req[2]=1 Data[2]=8'hA5, Last on 3rd beat -> Gnt=4'b0100 one cycle later, Bus=8'h5A 3 cycles, then 'z, Gnt=0.
//  Req=4'b1111 held, Last=0 -> owners 0,1,2,3,0 each 4 beats, Gnt low exactly 2 cycles between bursts.
//  Req[1] drops after 2 beats -> next edge TURN, Bus 'z; next Req[1] grant starts count at 0, allows 4 beats.
//  Rst during DRIVE beat 2 of ch2, then Req=4'b1001 -> after release channel 0 granted first, then channel 3.
//  INVERT=0 build, Data[0]=8'h3C -> Bus=8'h3C while Gnt[0]=1.

Source files
------------

// File: rtl/tristate_bus_arbiter_pkg.sv
// tristate_bus_arbiter_pkg: shared state encoding and width helper for the tri-state bus arbiter
package tristate_bus_arbiter_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_TURN} state_t;
  function automatic int w_of(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/tristate_bus_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first requester at or after ptr
module rr_arbiter
  import tristate_bus_arbiter_pkg::*;
#(
  parameter int N = 4,
  parameter int IW = w_of(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
  logic [IW-1:0] j;
  always_comb begin
    idx = '0;
    j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = IW'((int'(ptr) + k) % N);
      idx = req[j] ? j : idx;
    end
    gnt = |req ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/tristate_bus_arbiter.sv
// tristate_bus_arbiter: round-robin burst arbiter driving one shared tri-state bus with turnaround gaps
module tristate_bus_arbiter
  import tristate_bus_arbiter_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 8,
  parameter int MAX_BURST = 4,
  parameter int TURN_CYC = 1,
  parameter int INVERT = 1
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [N-1:0]         Req,
  input  logic [N*W-1:0]       Data,
  input  logic [N-1:0]         Last,
  output logic [N-1:0]         Gnt,
  inout  wire  [W-1:0]         Bus,
  output logic                 BusValid,
  output logic [w_of(N)-1:0]   Owner
);
  localparam int IW = w_of(N);
  localparam int CW = w_of(MAX_BURST + 1);
  localparam int TW = w_of(TURN_CYC);
  state_t state_q, state_d;
  logic [N-1:0] gnt_q, gnt_d, arb_gnt;
  logic [IW-1:0] owner_q, owner_d, ptr_q, ptr_d, arb_idx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] turn_q, turn_d;
  logic [W-1:0] beat;
  logic drive, own_req, own_last, hit;

  rr_arbiter #(.N(N)) u_arb (
    .req(Req),
    .ptr(ptr_q),
    .gnt(arb_gnt),
    .idx(arb_idx)
  );

  assign drive = state_q == ST_DRIVE;
  assign own_req = |(Req & gnt_q);
  assign own_last = |(Last & gnt_q);
  assign hit = MAX_BURST != 0 && int'(cnt_q) + 1 == MAX_BURST;
  assign beat = W'(Data >> (int'(owner_q) * W));
  assign Bus = drive ? (INVERT != 0 ? ~beat : beat) : 'z;
  assign BusValid = drive && own_req;
  assign Gnt = gnt_q;
  assign Owner = owner_q;

  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    owner_d = owner_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    turn_d = turn_q;
    if (state_q == ST_IDLE && |Req) begin
      state_d = ST_DRIVE;
      gnt_d = arb_gnt;
      owner_d = arb_idx;
      cnt_d = '0;
    end
    if (drive && own_req && cnt_q != '1) cnt_d = cnt_q + 1'b1;
    if (drive && (!own_req || own_last || hit)) begin
      state_d = ST_TURN;
      gnt_d = '0;
      ptr_d = owner_q == IW'(N - 1) ? '0 : owner_q + 1'b1;
      turn_d = '0;
    end
    if (state_q == ST_TURN) begin
      turn_d = turn_q + 1'b1;
      state_d = int'(turn_q) == TURN_CYC - 1 ? ST_IDLE : ST_TURN;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      gnt_q <= '0;
      owner_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
      turn_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      owner_q <= owner_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      turn_q <= turn_d;
    end
  end
endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// tb_tristate_bus_arbiter: scoreboard bench for inverting and non-inverting arbiter builds
module tb_tristate_bus_arbiter;
  logic clk = 0;
  logic rst = 1;
  logic [3:0] req = '0;
  logic [3:0] last = '0;
  logic [31:0] data = '0;
  wire [3:0] gnt, gnt0;
  wire [7:0] bus, bus0;
  wire bv, bv0;
  wire [1:0] own, own0;

  tristate_bus_arbiter #(.N(4), .W(8), .MAX_BURST(4), .TURN_CYC(1), .INVERT(1)) dut (
    .Clk(clk), .Rst(rst), .Req(req), .Data(data), .Last(last),
    .Gnt(gnt), .Bus(bus), .BusValid(bv), .Owner(own)
  );

  tristate_bus_arbiter #(.N(4), .W(8), .MAX_BURST(4), .TURN_CYC(1), .INVERT(0)) dut0 (
    .Clk(clk), .Rst(rst), .Req(req), .Data(data), .Last(last),
    .Gnt(gnt0), .Bus(bus0), .BusValid(bv0), .Owner(own0)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] own;
    logic bv;
    logic [7:0] bus;
    logic [7:0] bus0;
  } exp_t;
  exp_t sb[$];

  int errors = 0;
  int checks = 0;
  int m_st = 0, m_own = 0, m_ptr = 0, m_cnt = 0, m_tc = 0;
  logic [3:0] o_gnt;
  logic [1:0] o_own;
  logic o_bv;
  logic [7:0] o_bus, o_bus0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic [3:0] rq, input logic [31:0] d, input logic [3:0] l);
    exp_t e, p;
    bit found;
    @(negedge clk);
    rst = r;
    req = rq;
    data = d;
    last = l;
    e.gnt = m_st == 1 ? 4'(1 << m_own) : 4'b0;
    e.own = 2'(m_own);
    e.bv = m_st == 1 && rq[m_own];
    e.bus = m_st == 1 ? ~8'(d >> (m_own * 8)) : 8'bz;
    e.bus0 = m_st == 1 ? 8'(d >> (m_own * 8)) : 8'bz;
    sb.push_back(e);
    #1;
    o_gnt = gnt;
    o_own = own;
    o_bv = bv;
    o_bus = bus;
    o_bus0 = bus0;
    p = sb.pop_front();
    chk("gnt", o_gnt, p.gnt);
    chk("owner", o_own, p.own);
    chk("busvalid", o_bv, p.bv);
    chk("bus", o_bus, p.bus);
    chk("bus_noinv", o_bus0, p.bus0);
    @(posedge clk);
    if (r) begin
      m_st = 0; m_own = 0; m_ptr = 0; m_cnt = 0; m_tc = 0;
    end else if (m_st == 0) begin
      found = 0;
      for (int k = 0; k < 4; k++)
        if (!found && rq[(m_ptr + k) % 4]) begin
          found = 1;
          m_own = (m_ptr + k) % 4;
        end
      if (found) begin
        m_st = 1;
        m_cnt = 0;
      end
    end else if (m_st == 1) begin
      if (!rq[m_own]) m_st = 2;
      else begin
        m_cnt++;
        if (l[m_own] || m_cnt == 4) m_st = 2;
      end
      if (m_st == 2) begin
        m_ptr = (m_own + 1) % 4;
        m_tc = 0;
      end
    end else begin
      m_tc++;
      if (m_tc == 1) m_st = 0;
    end
  endtask

  initial begin
    int n5a, ng, nb, zr, br, g, ord_n;
    int beats[8];
    int ord[4];
    int seq[5];
    logic [3:0] pg, rq;
    bit dropped, seen0;
    seq = '{0, 1, 2, 3, 0};

    step(1, 4'b1111, 32'h0, 4'b0);
    step(1, 4'b1111, 32'h0, 4'b0);

    n5a = 0;
    ng = 0;
    for (int c = 0; c < 6; c++) begin
      step(0, 4'b0100, 32'h00A5_0000, (m_st == 1 && m_cnt == 2) ? 4'b0100 : 4'b0);
      if (o_bus === 8'h5A) n5a++;
      if (o_gnt === 4'b0100) ng++;
    end
    chk("last3_bus_beats", n5a, 3);
    chk("last3_gnt_cycles", ng, 3);
    for (int c = 0; c < 4; c++) step(0, 4'b0, 32'h0, 4'b0);

    step(1, 4'b0, 32'h0, 4'b0);
    nb = 0; zr = 0; br = 0;
    for (int c = 0; c < 32; c++) begin
      step(0, 4'b1111, 32'h1122_3344, 4'b0);
      if (o_gnt != 0) begin
        if (br == 0) begin
          if (nb > 0 && nb < 5) chk("rr_gap", zr, 2);
          if (nb < 5) chk("rr_owner", o_own, seq[nb]);
          nb++;
          zr = 0;
        end
        br++;
      end else begin
        if (br > 0 && nb <= 5) chk("rr_burst_len", br, 4);
        br = 0;
        zr++;
      end
    end
    chk("rr_bursts_seen", nb >= 5, 1);

    step(1, 4'b0, 32'h0, 4'b0);
    dropped = 0; g = 0; pg = 0;
    foreach (beats[i]) beats[i] = 0;
    for (int c = 0; c < 16; c++) begin
      rq = 4'b0010;
      if (!dropped && m_st == 1 && m_cnt == 2) begin
        rq = 4'b0;
        dropped = 1;
      end
      step(0, rq, 32'h0000_7700, 4'b0);
      if (o_gnt != 0 && pg == 0 && g < 7) g++;
      if (o_bv) beats[g]++;
      pg = o_gnt;
    end
    chk("drop_first_beats", beats[1], 2);
    chk("drop_regrant_beats", beats[2], 4);

    step(1, 4'b0, 32'h0, 4'b0);
    for (int c = 0; c < 10; c++) begin
      if (m_st == 1 && m_cnt == 1) begin
        step(1, 4'b0100, 32'h00A5_003C, 4'b0);
        break;
      end
      step(0, 4'b0100, 32'h00A5_003C, 4'b0);
    end
    ord_n = 0; pg = 0; seen0 = 0;
    ord = '{-1, -1, -1, -1};
    for (int c = 0; c < 14; c++) begin
      step(0, 4'b1001, 32'h00A5_003C, 4'b0);
      if (o_gnt != 0 && pg == 0 && ord_n < 4) begin
        ord[ord_n] = o_own;
        ord_n++;
      end
      if (o_gnt == 4'b0001 && !seen0) begin
        seen0 = 1;
        chk("noinv_bus_3c", o_bus0, 8'h3C);
      end
      pg = o_gnt;
    end
    chk("rst_first_owner", ord[0], 0);
    chk("rst_second_owner", ord[1], 3);
    chk("noinv_seen", seen0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
